// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests words from instruction memory, holds the
// fetched instruction in a register and presents its decoded fields until accepted.
module instruction_fetch #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  output logic               instrValid,
  input  logic               instrReady,
  output logic [2:0]         opcode,
  output logic [2:0]         rs,
  output logic [2:0]         rt,
  output logic [2:0]         rd,
  output logic [6:0]         imm,
  input  logic               jumpSelect,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imemAck) begin
          ir_d    = imemData;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instrReady) begin
          // Opcode 000 is HALT: stop without advancing pc so it points at the halt.
          if (opcode == 3'b000) begin
            state_d = HALT;
          end else begin
            pc_d    = jumpSelect ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign imemReq    = (state_q == FETCH);
  assign imemAddr   = pc_q;
  assign instrValid = (state_q == ISSUE);
  assign halted     = (state_q == HALT);
  assign pc         = pc_q;

  assign opcode = ir_q[INSTR_W-1  -: 3];
  assign rs     = ir_q[INSTR_W-4  -: 3];
  assign rt     = ir_q[INSTR_W-7  -: 3];
  assign rd     = ir_q[INSTR_W-10 -: 3];
  assign imm    = ir_q[6:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a behavioural
// instruction memory whose ack latency is programmable.
module tb_instruction_fetch;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  logic               clk;
  logic               rst_n;
  logic               imemReq;
  logic [ADDR_W-1:0]  imemAddr;
  logic               imemAck;
  logic [INSTR_W-1:0] imemData;
  logic               instrValid;
  logic               instrReady;
  logic [2:0]         opcode, rs, rt, rd;
  logic [6:0]         imm;
  logic               jumpSelect;
  logic [ADDR_W-1:0]  pc;
  logic               halted;

  logic [INSTR_W-1:0] mem [256];
  int                 ack_delay;
  int                 wait_cnt;
  logic               ack_force;
  int                 n_tests;
  int                 n_fail;

  instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemAck    (imemAck),
    .imemData   (imemData),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .jumpSelect (jumpSelect),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack once the request has waited ack_delay cycles; ack_force
  // injects a spurious ack carrying a poison word.
  assign imemAck  = ack_force | (imemReq & (wait_cnt >= ack_delay));
  assign imemData = ack_force ? 16'hFFFF : mem[imemAddr];

  always @(posedge clk) begin
    if (imemReq && !imemAck) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [ADDR_W-1:0] addr);
    check({tag, "_req"},   32'(imemReq), 32'd1);
    check({tag, "_valid"}, 32'(instrValid), 32'd0);
    check({tag, "_addr"},  32'(imemAddr), 32'(addr));
  endtask

  task automatic expect_issue(input string tag, input logic [2:0] op);
    check({tag, "_req"},   32'(imemReq), 32'd0);
    check({tag, "_valid"}, 32'(instrValid), 32'd1);
    check({tag, "_op"},    32'(opcode), 32'(op));
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    instrReady = 1'b1;
    jumpSelect = 1'b0;
    ack_delay  = 0;
    ack_force  = 1'b0;
    wait_cnt   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    mem[0]    = 16'h8000;
    mem[1]    = 16'hA000;
    mem[2]    = 16'hC000;
    mem[3]    = 16'hB5AC;
    mem[4]    = 16'h6040;
    mem[8'h40]= 16'h6005;
    mem[5]    = 16'h6005;
    mem[6]    = 16'h60FF;
    mem[8'hFF]= 16'h8000;

    #3;
    check("rst_req",    32'(imemReq), 32'd0);
    check("rst_valid",  32'(instrValid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc",     32'(pc), 32'd0);
    tick();
    check("rst_hold_req", 32'(imemReq), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_pc", 32'(pc), 32'd0);

    // Zero-wait stream: add, addi, sub
    expect_fetch("f0", 8'd0);
    tick(); expect_issue("i0", 3'b100);
    tick(); expect_fetch("f1", 8'd1);
    tick(); expect_issue("i1", 3'b101);
    tick(); expect_fetch("f2", 8'd2);
    tick(); expect_issue("i2", 3'b110);
    ack_delay = 2;

    // Ack arrives on the third requesting cycle
    tick(); expect_fetch("d0", 8'd3); check("d0_pc", 32'(pc), 32'd3);
    tick(); expect_fetch("d1", 8'd3); check("d1_pc", 32'(pc), 32'd3);
    tick(); expect_fetch("d2", 8'd3); check("d2_ack", 32'(imemAck), 32'd1);
    instrReady = 1'b0;
    tick(); expect_issue("d3", 3'b101);
    ack_delay = 0;
    ack_force = 1'b1;

    // Stalled issue with a spurious ack that must not reload the IR
    for (int k = 0; k < 4; k++) begin
      check("stall_valid", 32'(instrValid), 32'd1);
      check("stall_req",   32'(imemReq), 32'd0);
      check("stall_pc",    32'(pc), 32'd3);
      check("stall_fields", {17'd0, opcode, rs, rt, rd, imm}, {17'd0, 3'd5, 3'd5, 3'd3, 3'd2, 7'h2C});
      tick();
    end
    ack_force  = 1'b0;
    instrReady = 1'b1;
    check("stall_end_valid", 32'(instrValid), 32'd1);
    tick(); expect_fetch("seq4", 8'd4);
    tick(); expect_issue("j40", 3'b011);
    jumpSelect = 1'b1;
    tick(); expect_fetch("jmp_40", 8'h40);
    tick(); expect_issue("j05", 3'b011);
    tick(); expect_fetch("jmp_05", 8'h05);
    tick(); expect_issue("nj05", 3'b011);
    jumpSelect = 1'b0;
    tick(); expect_fetch("nojmp_06", 8'h06);
    tick(); expect_issue("jff", 3'b011);
    jumpSelect = 1'b1;
    tick(); expect_fetch("jmp_ff", 8'hFF);
    tick(); expect_issue("wrap_i", 3'b100);
    jumpSelect = 1'b0;
    tick(); expect_fetch("wrap_00", 8'h00);
    tick(); expect_issue("h_pre", 3'b100);
    mem[1] = 16'h0000;
    tick(); expect_fetch("h_f", 8'h01);
    tick(); expect_issue("h_i", 3'b000);
    jumpSelect = 1'b1;
    tick();
    ack_force = 1'b1;

    // HALT must absorb everything except reset
    for (int k = 0; k < 12; k++) begin
      check("halt_flag",  32'(halted), 32'd1);
      check("halt_req",   32'(imemReq), 32'd0);
      check("halt_valid", 32'(instrValid), 32'd0);
      check("halt_pc",    32'(pc), 32'd1);
      tick();
    end
    ack_force  = 1'b0;
    jumpSelect = 1'b0;
    mem[1]     = 16'h8000;

    #2 rst_n = 1'b0;
    #1;
    check("async_halted", 32'(halted), 32'd0);
    check("async_pc",     32'(pc), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); expect_fetch("r1_f0", 8'd0);
    check("r1_halted", 32'(halted), 32'd0);
    tick(); expect_issue("r1_i0", 3'b100);
    ack_delay = 5;
    tick(); expect_fetch("r1_f1", 8'd1);
    check("r1_noack", 32'(imemAck), 32'd0);

    // Reset pulse in the middle of a pending fetch
    #3 rst_n = 1'b0;
    #1;
    check("midf_req",   32'(imemReq), 32'd0);
    check("midf_pc",    32'(pc), 32'd0);
    check("midf_valid", 32'(instrValid), 32'd0);
    tick();
    rst_n     = 1'b1;
    ack_delay = 0;
    tick(); expect_fetch("r2_f0", 8'd0);
    check("r2_halted", 32'(halted), 32'd0);
    tick(); expect_issue("r2_i0", 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the program-counter and instruction-address width in words.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width; opcode is always instr[INSTR_W-1 -: 3].
REQ-003 Ports SHALL be exactly as follows:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imemReq  output  1  instruction memory read request.
- imemAddr  output  ADDR_W  word address of the request, always equal to pc.
- imemAck  input  1  memory read data valid this cycle.
- imemData  input  INSTR_W  instruction word, sampled only when imemReq and imemAck are both 1.
- instrValid  output  1  decoded fields are valid for the control unit.
- instrReady  input  1  downstream accepts the current instruction.
- opcode  output  3  instr[15:13], feeds control_unit.
- rs / rt / rd  output  3 each  instr[12:10] / instr[9:7] / instr[6:4].
- imm  output  7  instr[6:0], zero-extended downstream.
- jumpSelect  input  1  from control_unit, sampled on instruction acceptance.
- pc  output  ADDR_W  current program counter.
- halted  output  1  fetch stopped on HALT opcode.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, FETCH, ISSUE, HALT.
REQ-005 IDLE SHALL go to FETCH on the first rising edge after rst_n deasserts; no request is issued in IDLE.
REQ-006 imemReq SHALL be 1 only in FETCH and SHALL stay asserted until imemAck is sampled high.
REQ-007 In FETCH with imemAck=1, the instruction register SHALL load imemData and the FSM SHALL go to ISSUE on the same edge.
- Zero-wait memory (ack in the same cycle as req) is legal.
- imemAck seen outside FETCH SHALL be ignored.
REQ-008 instrValid SHALL be 1 only in ISSUE, with opcode/rs/rt/rd/imm driven directly from the instruction register and held stable until acceptance.
REQ-009 Acceptance SHALL occur on a rising edge in ISSUE with instrReady=1.
REQ-010 On acceptance with opcode=000, the FSM SHALL go to HALT, pc SHALL be unchanged, and halted SHALL go to 1.
REQ-011 On acceptance with opcode≠000 and jumpSelect=1, pc SHALL load instr[ADDR_W-1:0] and the FSM SHALL go to FETCH.
REQ-012 On acceptance with opcode≠000 and jumpSelect=0, pc SHALL load pc+1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0) and the FSM SHALL go to FETCH.
REQ-013 HALT SHALL be absorbing: no requests, instrValid=0; only reset exits it.
REQ-014 Best-case throughput SHALL be one instruction per 2 cycles (FETCH + ISSUE).
REQ-015 pc SHALL change only on acceptance.

Reset
REQ-016 Asserting rst_n=0 SHALL immediately, independent of clk, set state=IDLE, pc=0, instruction register=0, imemReq=0, instrValid=0, halted=0.
REQ-017 Reset asserted during FETCH or ISSUE SHALL abandon the in-flight instruction; the first request after release SHALL be to address 0.

Verification
REQ-018 The bench SHALL cover at least these scenarios:
- Reset then zero-wait memory holding 0x8000,0xA000,0xC000 (add, addi, sub), instrReady=1: imemAddr 0,1,2; instrValid every 2nd cycle; opcodes 100,101,110.
- Memory ack delayed 3 cycles: imemReq held 3 cycles at the same address; IR captured only on the ack edge; pc unchanged.
- instrValid with instrReady=0 for 4 cycles: fields stable, no new imemReq, pc stable.
- Instruction 0x6005 with jumpSelect=1 on accept: next imemAddr=0x05; with jumpSelect=0 it is pc+1.
- pc=0xFF, non-jump accepted: next imemAddr=0x00.
- Opcode 000 accepted: halted=1, imemReq stays 0 for 10+ cycles; mid-FETCH rst_n pulse restarts at address 0 with halted=0.
